// File: rtl/ame_solver_arbiter.sv
// Round-robin sequencer sharing one AME equation solver: init 1 cycle after accept, response 1 cycle after done.
// Backpressure: no request is granted while a job or its response is outstanding; rsp_* holds until rsp_ready_i.
module ame_solver_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int COMP_DATA_BITS = 64,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic                                                  clk_i,
   input  logic                                                  rst_n_i,
   input  logic [NUM_REQ-1:0]                                    req_valid_i,
   output logic [NUM_REQ-1:0]                                    req_ready_o,
   input  logic [NUM_REQ-1:0]                                    req_param6_i,
   input  logic [NUM_REQ-1:0][5:0][6:0][COMP_DATA_BITS-1:0]      req_data_i,
   output logic                                                  solver_init_o,
   output logic                                                  solver_param6_o,
   output logic [5:0][6:0][COMP_DATA_BITS-1:0]                   solver_data_o,
   input  logic                                                  solver_done_i,
   input  logic [5:0][COMP_DATA_BITS-1:0]                        solver_data_i,
   output logic                                                  rsp_valid_o,
   input  logic                                                  rsp_ready_i,
   output logic [$clog2(NUM_REQ)-1:0]                            rsp_id_o,
   output logic                                                  rsp_timeout_o,
   output logic [5:0][COMP_DATA_BITS-1:0]                        rsp_data_o,
   output logic                                                  busy_o
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT,
      S_RESP,
      S_FLUSH
   } state_t;

   state_t                                r_state;
   state_t                                w_state_nxt;
   logic [ID_W-1:0]                       r_rr_ptr;
   logic [CNT_W-1:0]                      r_cnt;
   logic                                  r_flush_pend;
   logic                                  r_param6;
   logic [5:0][6:0][COMP_DATA_BITS-1:0]   r_sdata;
   logic                                  r_rsp_vld;
   logic [ID_W-1:0]                       r_rsp_id;
   logic                                  r_rsp_tmo;
   logic [5:0][COMP_DATA_BITS-1:0]        r_rsp_data;

   int                                    w_scan;
   logic [ID_W-1:0]                       w_scan_idx;
   logic                                  w_gnt_vld;
   logic [ID_W-1:0]                       w_gnt_id;
   logic [ID_W-1:0]                       w_rr_nxt;
   logic [NUM_REQ-1:0]                    w_rdy;
   logic                                  w_accept;
   logic                                  w_cnt_last;
   logic                                  w_done_cap;
   logic                                  w_tmo;
   logic                                  w_rsp_hs;

   // First valid requester at or after the round-robin pointer, wrapping.
   always_comb begin
      w_scan     = 0;
      w_scan_idx = '0;
      w_gnt_vld  = 1'b0;
      w_gnt_id   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_scan     = (int'(r_rr_ptr) + i) % NUM_REQ;
         w_scan_idx = ID_W'(w_scan);
         if (!w_gnt_vld && req_valid_i[w_scan_idx]) begin
            w_gnt_vld = 1'b1;
            w_gnt_id  = w_scan_idx;
         end
      end
   end

   always_comb begin
      w_rdy = '0;
      if (r_state == S_IDLE && w_gnt_vld) begin
         w_rdy[w_gnt_id] = 1'b1;
      end
   end

   assign w_accept   = (r_state == S_IDLE) && w_gnt_vld;
   assign w_rr_nxt   = (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
   assign w_cnt_last = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign w_rsp_hs   = r_rsp_vld && rsp_ready_i;

   // Done beats the watchdog when both land in the same WAIT cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_done_cap  = 1'b0;
      w_tmo       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (solver_done_i) begin
               w_done_cap  = 1'b1;
               w_state_nxt = S_RESP;
            end else if (w_cnt_last) begin
               w_tmo       = 1'b1;
               w_state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            if (w_rsp_hs) begin
               w_state_nxt = r_flush_pend ? S_FLUSH : S_IDLE;
            end
         end
         S_FLUSH: begin
            if (solver_done_i) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_rr_ptr     <= '0;
         r_cnt        <= '0;
         r_flush_pend <= 1'b0;
         r_param6     <= 1'b0;
         r_sdata      <= '0;
         r_rsp_vld    <= 1'b0;
         r_rsp_id     <= '0;
         r_rsp_tmo    <= 1'b0;
         r_rsp_data   <= '0;
      end else begin
         if (w_accept) begin
            r_sdata  <= req_data_i[w_gnt_id];
            r_param6 <= req_param6_i[w_gnt_id];
            r_rsp_id <= w_gnt_id;
            r_rr_ptr <= w_rr_nxt;
         end

         if (r_state == S_LAUNCH) begin
            r_cnt <= '0;
         end else if (r_state == S_WAIT && !w_done_cap && !w_tmo) begin
            r_cnt <= r_cnt + 1'b1;
         end

         if (w_done_cap) begin
            r_rsp_data <= solver_data_i;
            r_rsp_tmo  <= 1'b0;
            r_rsp_vld  <= 1'b1;
         end else if (w_tmo) begin
            r_rsp_data   <= '0;
            r_rsp_tmo    <= 1'b1;
            r_rsp_vld    <= 1'b1;
            r_flush_pend <= 1'b1;
         end else if (r_state == S_RESP && w_rsp_hs) begin
            r_rsp_vld <= 1'b0;
         end

         // The late done of a timed-out job is swallowed here.
         if (r_state == S_FLUSH && solver_done_i) begin
            r_flush_pend <= 1'b0;
         end
      end
   end

   assign req_ready_o     = w_rdy;
   assign solver_init_o   = (r_state == S_LAUNCH);
   assign solver_param6_o = r_param6;
   assign solver_data_o   = r_sdata;
   assign rsp_valid_o     = r_rsp_vld;
   assign rsp_id_o        = r_rsp_id;
   assign rsp_timeout_o   = r_rsp_tmo;
   assign rsp_data_o      = r_rsp_data;
   assign busy_o          = (r_state != S_IDLE);

endmodule

// File: tb/tb_ame_solver_arbiter.sv
// Directed bench for ame_solver_arbiter: job table plus reset-in-WAIT sequence.
module tb_ame_solver_arbiter;

   localparam int NR  = 4;
   localparam int W   = 16;
   localparam int TMO = 24; // long enough that a 20-cycle solver latency completes normally

   logic                            clk;
   logic                            rst_n;
   logic [NR-1:0]                   req_valid;
   logic [NR-1:0]                   req_ready;
   logic [NR-1:0]                   req_param6;
   logic [NR-1:0][5:0][6:0][W-1:0]  req_data;
   logic                            solver_init;
   logic                            solver_param6;
   logic [5:0][6:0][W-1:0]          solver_data_o;
   logic                            solver_done;
   logic [5:0][W-1:0]               solver_data_i;
   logic                            rsp_valid;
   logic                            rsp_ready;
   logic [1:0]                      rsp_id;
   logic                            rsp_timeout;
   logic [5:0][W-1:0]               rsp_data;
   logic                            busy;

   ame_solver_arbiter #(
      .NUM_REQ        (NR),
      .COMP_DATA_BITS (W),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk_i           (clk),
      .rst_n_i         (rst_n),
      .req_valid_i     (req_valid),
      .req_ready_o     (req_ready),
      .req_param6_i    (req_param6),
      .req_data_i      (req_data),
      .solver_init_o   (solver_init),
      .solver_param6_o (solver_param6),
      .solver_data_o   (solver_data_o),
      .solver_done_i   (solver_done),
      .solver_data_i   (solver_data_i),
      .rsp_valid_o     (rsp_valid),
      .rsp_ready_i     (rsp_ready),
      .rsp_id_o        (rsp_id),
      .rsp_timeout_o   (rsp_timeout),
      .rsp_data_o      (rsp_data),
      .busy_o          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int n_rdy_bad = 0;

   always @(negedge clk) begin
      if (rst_n && !$onehot0(req_ready)) n_rdy_bad++;
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_w(input string nm, input logic [671:0] act, input logic [671:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [NR-1:0] mask;
      logic          p6;
      int            id;
      int            dly;   // cycles from init to done; 0 = solver never answers
      int            hold;  // cycles of response backpressure
   } job_t;

   job_t tbl[12];

   // Entered and left on a negedge with the arbiter in IDLE.
   task automatic run_job(input job_t j, input int jn);
      logic [5:0][W-1:0] res;
      logic [5:0][W-1:0] expd;
      logic [101:0]      snap;
      int                bad;
      int                n;
      req_param6[j.id] = j.p6;
      req_valid = j.mask;
      #1;
      chk($sformatf("grant job%0d", jn), int'(req_ready), 1 << j.id);
      chk($sformatf("idle_busy job%0d", jn), int'(busy), 0);

      @(negedge clk);
      chk($sformatf("init job%0d", jn), int'(solver_init), 1);
      chk($sformatf("param6 job%0d", jn), int'(solver_param6), int'(j.p6));
      chk_w($sformatf("sdata job%0d", jn), 672'(solver_data_o), 672'(req_data[j.id]));
      chk($sformatf("launch_ready job%0d", jn), int'(req_ready), 0);

      for (int k = 0; k < 6; k++) res[k] = W'(jn * 16 + k + 1);
      n = (j.dly == 0) ? TMO : j.dly;
      bad = 0;
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         if (solver_init || rsp_valid || req_ready != '0) bad++;
         if (j.dly != 0 && k == n) begin
            solver_done   = 1'b1;
            solver_data_i = res;
         end
      end
      chk($sformatf("wait_quiet job%0d", jn), bad, 0);

      @(negedge clk);
      solver_done   = 1'b0;
      solver_data_i = '1;
      expd = (j.dly == 0) ? '0 : res;
      chk($sformatf("rsp_valid job%0d", jn), int'(rsp_valid), 1);
      chk($sformatf("rsp_id job%0d", jn), int'(rsp_id), j.id);
      chk($sformatf("rsp_tmo job%0d", jn), int'(rsp_timeout), (j.dly == 0) ? 1 : 0);
      chk_w($sformatf("rsp_data job%0d", jn), 672'(rsp_data), 672'(expd));

      if (j.hold > 0) begin
         snap = {rsp_valid, rsp_id, rsp_timeout, rsp_data, busy};
         bad = 0;
         for (int h = 0; h < j.hold; h++) begin
            @(negedge clk);
            if ({rsp_valid, rsp_id, rsp_timeout, rsp_data, busy} !== snap) bad++;
            if (req_ready != '0) bad++;
         end
         chk($sformatf("bp_stable job%0d", jn), bad, 0);
      end

      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk($sformatf("rsp_clear job%0d", jn), int'(rsp_valid), 0);

      if (j.dly == 0) begin
         chk($sformatf("flush_busy job%0d", jn), int'(busy), 1);
         bad = 0;
         for (int h = 0; h < 4; h++) begin
            @(negedge clk);
            if (!busy || req_ready != '0) bad++;
         end
         chk($sformatf("flush_hold job%0d", jn), bad, 0);
         solver_done = 1'b1;
         @(negedge clk);
         solver_done = 1'b0;
      end
      chk($sformatf("back_idle job%0d", jn), int'(busy), 0);
   endtask

   initial begin
      rst_n         = 1'b0;
      req_valid     = '0;
      req_param6    = '0;
      solver_done   = 1'b0;
      solver_data_i = '0;
      rsp_ready     = 1'b0;
      for (int r = 0; r < NR; r++)
         for (int row = 0; row < 6; row++)
            for (int col = 0; col < 7; col++)
               if (r == 2)
                  req_data[r][row][col] = (col == 6) ? W'(row + 1) : W'(row == col);
               else
                  req_data[r][row][col] = W'(r * 256 + row * 16 + col + 1);

      tbl[0]  = '{4'hF, 1'b0, 0, 3, 0};
      tbl[1]  = '{4'hF, 1'b1, 1, 5, 0};
      tbl[2]  = '{4'hF, 1'b0, 2, 2, 10};
      tbl[3]  = '{4'hF, 1'b1, 3, 4, 0};
      tbl[4]  = '{4'hF, 1'b0, 0, 1, 0};
      tbl[5]  = '{4'hF, 1'b1, 1, 6, 0};
      tbl[6]  = '{4'hF, 1'b0, 2, 3, 0};
      tbl[7]  = '{4'hF, 1'b1, 3, 2, 0};
      tbl[8]  = '{4'h4, 1'b1, 2, 20, 0};
      tbl[9]  = '{4'h3, 1'b0, 0, 1, 0};
      tbl[10] = '{4'h8, 1'b1, 3, 0, 0};
      tbl[11] = '{4'h2, 1'b0, 1, TMO, 0};

      @(negedge clk);
      @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_init", int'(solver_init), 0);
      chk("rst_rsp_valid", int'(rsp_valid), 0);
      chk_w("rst_sdata", 672'(solver_data_o), 672'(0));
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) run_job(tbl[i], i);

      // Reset in the middle of WAIT: job dropped, pointer back to 0.
      req_valid = 4'b0100;
      @(negedge clk);
      req_valid = '0;
      chk("rw_init", int'(solver_init), 1);
      repeat (5) @(negedge clk);
      chk("rw_busy", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      chk("rw_busy0", int'(busy), 0);
      chk("rw_param6", int'(solver_param6), 0);
      chk("rw_rsp", int'({rsp_valid, rsp_id, rsp_timeout}), 0);
      chk_w("rw_sdata", 672'(solver_data_o), 672'(0));
      chk_w("rw_rdata", 672'(rsp_data), 672'(0));
      @(negedge clk);
      rst_n     = 1'b1;
      req_valid = 4'b1010;
      #1;
      chk("rw_grant", int'(req_ready), 2);
      @(negedge clk);
      req_valid = '0;
      chk("rw_rsp_id", int'(rsp_id), 1);
      chk("rw_launch", int'(solver_init), 1);

      chk("ready_onehot0", n_rdy_bad, 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
